// File: rtl/if_fetch_ctrl.sv
// Fetch sequencer ahead of IF1: owns the fetch PC, issues one aligned icache read per
// fetch group with at most one outstanding, and squashes stale lines after a redirect.
module if_fetch_ctrl #(
  parameter logic [31:0] RESET_PC      = 32'h1c000000,
  parameter int          IB_WIDTH_LOG2 = 4
) (
  input  logic                     clk,
  input  logic                     resetn,
  input  logic                     redirect_valid,
  input  logic [31:0]              redirect_pc,
  input  logic [IB_WIDTH_LOG2:0]   ib_free,
  output logic                     req_valid,
  output logic [31:0]              req_addr,
  input  logic                     addr_ok,
  input  logic                     data_ok,
  output logic                     if1_valid,
  output logic [31:0]              if1_pc,
  output logic [2:0]               if1_num,
  output logic                     flush_if
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_REQ,
    S_WAIT,
    S_CANCEL
  } state_t;

  localparam logic [IB_WIDTH_LOG2:0] GRP_INSNS = 4;

  state_t      r_state;
  state_t      w_state_nxt;
  logic [31:0] r_pc;
  logic [31:0] r_grp_pc;
  logic [31:0] w_pc_nxt;
  logic [31:0] w_grp_pc_nxt;
  logic [31:0] w_redir_pc;
  logic        w_redirect;
  logic        w_room;
  logic        w_req_valid;
  logic        w_if1_valid;

  assign w_redir_pc = redirect_pc & ~32'h3;
  assign w_redirect = redirect_valid && (r_state != S_IDLE);
  // Only request when the buffer can take a whole group, so IF1 never overflows it.
  assign w_room     = (ib_free >= GRP_INSNS);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state  <= S_IDLE;
      r_pc     <= RESET_PC;
      r_grp_pc <= '0;
    end else begin
      r_state  <= w_state_nxt;
      r_pc     <= w_pc_nxt;
      r_grp_pc <= w_grp_pc_nxt;
    end
  end

  always_comb begin
    w_state_nxt  = r_state;
    w_pc_nxt     = r_pc;
    w_grp_pc_nxt = r_grp_pc;
    w_req_valid  = 1'b0;
    w_if1_valid  = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_state_nxt = S_REQ;
      end
      S_REQ: begin
        // A redirect suppresses the request, so a simultaneous addr_ok cannot be taken.
        if (w_redirect) begin
          w_pc_nxt = w_redir_pc;
        end else begin
          w_req_valid = w_room;
          if (w_room && addr_ok) begin
            w_grp_pc_nxt = r_pc;
            w_pc_nxt     = {r_pc[31:4] + 28'd1, 4'b0000};
            w_state_nxt  = S_WAIT;
          end
        end
      end
      S_WAIT: begin
        if (w_redirect) begin
          w_pc_nxt    = w_redir_pc;
          w_state_nxt = data_ok ? S_REQ : S_CANCEL;
        end else if (data_ok) begin
          w_if1_valid = 1'b1;
          w_state_nxt = S_REQ;
        end
      end
      S_CANCEL: begin
        if (w_redirect) begin
          w_pc_nxt = w_redir_pc;
        end
        if (data_ok) begin
          w_state_nxt = S_REQ;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  assign req_valid = w_req_valid;
  assign req_addr  = resetn ? r_pc : '0;
  assign if1_valid = w_if1_valid;
  assign if1_pc    = w_if1_valid ? r_grp_pc : '0;
  // A group entered mid-line carries only the instructions from its word offset onward.
  assign if1_num   = w_if1_valid ? (3'd4 - {1'b0, r_grp_pc[3:2]}) : '0;
  assign flush_if  = w_redirect;

endmodule

// File: tb/tb_if_fetch_ctrl.sv
// Bench for if_fetch_ctrl: per-cycle vector table plus a scoreboard of issued fetch groups.
module tb_if_fetch_ctrl;

  localparam logic [31:0] RST_PC = 32'h1c000000;

  logic        clk = 1'b0;
  logic        resetn;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic [4:0]  ib_free;
  logic        req_valid;
  logic [31:0] req_addr;
  logic        addr_ok;
  logic        data_ok;
  logic        if1_valid;
  logic [31:0] if1_pc;
  logic [2:0]  if1_num;
  logic        flush_if;

  int n_chk  = 0;
  int n_fail = 0;

  if_fetch_ctrl #(.RESET_PC(RST_PC), .IB_WIDTH_LOG2(4)) dut (
    .clk            (clk),
    .resetn         (resetn),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .ib_free        (ib_free),
    .req_valid      (req_valid),
    .req_addr       (req_addr),
    .addr_ok        (addr_ok),
    .data_ok        (data_ok),
    .if1_valid      (if1_valid),
    .if1_pc         (if1_pc),
    .if1_num        (if1_num),
    .flush_if       (flush_if)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        rv;
    logic [31:0] rpc;
    logic [4:0]  free;
    logic        aok;
    logic        dok;
    logic        e_rqv;
    logic [31:0] e_addr;
    logic        e_if1v;
    logic [31:0] e_if1pc;
    logic [2:0]  e_num;
    logic        e_flush;
  } vec_t;

  typedef struct {
    logic [31:0] pc;
    logic [2:0]  num;
  } grp_t;

  vec_t tbl[$];
  grp_t sb[$];

  function automatic vec_t mk(logic rv, logic [31:0] rpc, logic [4:0] free, logic aok,
                              logic dok, logic e_rqv, logic [31:0] e_addr, logic e_if1v,
                              logic [31:0] e_if1pc, logic [2:0] e_num);
    vec_t v;
    v.rv = rv; v.rpc = rpc; v.free = free; v.aok = aok; v.dok = dok;
    v.e_rqv = e_rqv; v.e_addr = e_addr; v.e_if1v = e_if1v;
    v.e_if1pc = e_if1pc; v.e_num = e_num; v.e_flush = rv;
    return v;
  endfunction

  task automatic chk(input string name, input int idx, input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s row %0d: got %h, expected %h", name, idx, act, exp);
    end
  endtask

  // Called one time unit after a rising edge; returns one time unit after the next.
  task automatic apply_row(input vec_t v, input int idx);
    grp_t g;
    redirect_valid = v.rv;
    redirect_pc    = v.rpc;
    ib_free        = v.free;
    addr_ok        = v.aok;
    data_ok        = v.dok;
    #4;
    chk("req_valid", idx, {31'd0, req_valid}, {31'd0, v.e_rqv});
    chk("req_addr",  idx, req_addr, v.e_addr);
    chk("if1_valid", idx, {31'd0, if1_valid}, {31'd0, v.e_if1v});
    chk("if1_pc",    idx, if1_pc, v.e_if1pc);
    chk("if1_num",   idx, {29'd0, if1_num}, {29'd0, v.e_num});
    chk("flush_if",  idx, {31'd0, flush_if}, {31'd0, v.e_flush});
    if (if1_valid === 1'b1) begin
      if (sb.size() == 0) begin
        n_chk++;
        n_fail++;
        $display("FAIL sb_unexpected row %0d: got line pc %h, expected no line", idx, if1_pc);
      end else begin
        g = sb.pop_front();
        chk("sb_pc",  idx, if1_pc, g.pc);
        chk("sb_num", idx, {29'd0, if1_num}, {29'd0, g.num});
      end
    end
    if (v.rv) sb.delete();
    else if (v.e_rqv && v.aok) begin
      g.pc  = v.e_addr;
      g.num = 3'd4 - {1'b0, v.e_addr[3:2]};
      sb.push_back(g);
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected end of test");
    $fatal(1, "watchdog");
  end

  initial begin
    resetn = 1'b0; redirect_valid = 1'b1; redirect_pc = 32'h0;
    ib_free = 5'd16; addr_ok = 1'b1; data_ok = 1'b1;

    // reset/IDLE, steady fetch
    tbl.push_back(mk(0, 0, 16, 0, 0, 0, 32'h1c000000, 0, 0, 0));
    tbl.push_back(mk(0, 0, 16, 1, 0, 1, 32'h1c000000, 0, 0, 0));
    tbl.push_back(mk(0, 0, 16, 0, 1, 0, 32'h1c000010, 1, 32'h1c000000, 4));
    tbl.push_back(mk(0, 0, 16, 1, 0, 1, 32'h1c000010, 0, 0, 0));
    tbl.push_back(mk(0, 0, 16, 0, 1, 0, 32'h1c000020, 1, 32'h1c000010, 4));
    // redirect in REQ, mid-line target
    tbl.push_back(mk(1, 32'h1c000108, 16, 1, 0, 0, 32'h1c000020, 0, 0, 0));
    tbl.push_back(mk(0, 0, 16, 1, 0, 1, 32'h1c000108, 0, 0, 0));
    tbl.push_back(mk(0, 0, 16, 0, 1, 0, 32'h1c000110, 1, 32'h1c000108, 2));
    tbl.push_back(mk(0, 0, 16, 1, 0, 1, 32'h1c000110, 0, 0, 0));
    // redirect in WAIT, late data dropped in CANCEL; low PC bits ignored
    tbl.push_back(mk(1, 32'h1c000203, 16, 0, 0, 0, 32'h1c000120, 0, 0, 0));
    tbl.push_back(mk(0, 0, 16, 0, 0, 0, 32'h1c000200, 0, 0, 0));
    tbl.push_back(mk(0, 0, 16, 0, 0, 0, 32'h1c000200, 0, 0, 0));
    tbl.push_back(mk(0, 0, 16, 0, 1, 0, 32'h1c000200, 0, 0, 0));
    tbl.push_back(mk(0, 0, 16, 1, 0, 1, 32'h1c000200, 0, 0, 0));
    // redirect with data_ok, then redirect with addr_ok
    tbl.push_back(mk(1, 32'h1c000300, 16, 0, 1, 0, 32'h1c000210, 0, 0, 0));
    tbl.push_back(mk(1, 32'h1c000400, 16, 1, 0, 0, 32'h1c000300, 0, 0, 0));
    // ib_free gating, stray data_ok in REQ, stray addr_ok in WAIT
    tbl.push_back(mk(0, 0, 3, 0, 0, 0, 32'h1c000400, 0, 0, 0));
    tbl.push_back(mk(0, 0, 3, 0, 1, 0, 32'h1c000400, 0, 0, 0));
    tbl.push_back(mk(0, 0, 4, 0, 0, 1, 32'h1c000400, 0, 0, 0));
    tbl.push_back(mk(0, 0, 16, 0, 0, 1, 32'h1c000400, 0, 0, 0));
    tbl.push_back(mk(0, 0, 2, 1, 0, 0, 32'h1c000400, 0, 0, 0));
    tbl.push_back(mk(0, 0, 4, 1, 0, 1, 32'h1c000400, 0, 0, 0));
    tbl.push_back(mk(0, 0, 16, 1, 0, 0, 32'h1c000410, 0, 0, 0));
    tbl.push_back(mk(0, 0, 16, 0, 1, 0, 32'h1c000410, 1, 32'h1c000400, 4));
    // back-to-back redirects through CANCEL, last one with data_ok
    tbl.push_back(mk(0, 0, 16, 1, 0, 1, 32'h1c000410, 0, 0, 0));
    tbl.push_back(mk(1, 32'h1c000504, 16, 0, 0, 0, 32'h1c000420, 0, 0, 0));
    tbl.push_back(mk(1, 32'h1c000600, 16, 0, 0, 0, 32'h1c000504, 0, 0, 0));
    tbl.push_back(mk(1, 32'h1c00060c, 16, 0, 1, 0, 32'h1c000600, 0, 0, 0));
    tbl.push_back(mk(0, 0, 16, 1, 0, 1, 32'h1c00060c, 0, 0, 0));
    tbl.push_back(mk(0, 0, 16, 0, 1, 0, 32'h1c000610, 1, 32'h1c00060c, 1));
    // PC wrap at the top of the address space
    tbl.push_back(mk(1, 32'hfffffff4, 16, 0, 0, 0, 32'h1c000610, 0, 0, 0));
    tbl.push_back(mk(0, 0, 16, 1, 0, 1, 32'hfffffff4, 0, 0, 0));
    tbl.push_back(mk(0, 0, 16, 0, 1, 0, 32'h00000000, 1, 32'hfffffff4, 3));
    tbl.push_back(mk(0, 0, 16, 1, 0, 1, 32'h00000000, 0, 0, 0));

    // Outputs held at zero under reset even with every input active.
    repeat (2) @(posedge clk);
    #1;
    chk("rst_req_valid", -1, {31'd0, req_valid}, 32'd0);
    chk("rst_req_addr",  -1, req_addr, 32'd0);
    chk("rst_if1_valid", -1, {31'd0, if1_valid}, 32'd0);
    chk("rst_flush_if",  -1, {31'd0, flush_if}, 32'd0);
    redirect_valid = 1'b0; addr_ok = 1'b0; data_ok = 1'b0;
    resetn = 1'b1;

    for (int i = 0; i < tbl.size(); i++) apply_row(tbl[i], i);

    // Asynchronous reset while a request is outstanding in WAIT.
    data_ok = 1'b1; addr_ok = 1'b1; redirect_valid = 1'b1; redirect_pc = 32'h1c000700;
    resetn = 1'b0;
    #1;
    chk("async_req_valid", 100, {31'd0, req_valid}, 32'd0);
    chk("async_req_addr",  100, req_addr, 32'd0);
    chk("async_if1_valid", 100, {31'd0, if1_valid}, 32'd0);
    chk("async_if1_pc",    100, if1_pc, 32'd0);
    chk("async_if1_num",   100, {29'd0, if1_num}, 32'd0);
    chk("async_flush_if",  100, {31'd0, flush_if}, 32'd0);
    sb.delete();
    @(posedge clk);
    #1;
    resetn = 1'b1;
    apply_row(mk(0, 0, 16, 0, 1, 0, RST_PC, 0, 0, 0), 101);
    apply_row(mk(0, 0, 16, 0, 1, 1, RST_PC, 0, 0, 0), 102);
    apply_row(mk(0, 0, 16, 1, 0, 1, RST_PC, 0, 0, 0), 103);
    apply_row(mk(0, 0, 16, 0, 1, 0, 32'h1c000010, 1, RST_PC, 4), 104);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
